channel_rx: RTL and testbench
=============================

# channel_rx

Receive endpoint for a fixed-latency `Channel` link. It accepts tagged words arriving from the forward channel and buffers them in a DEPTH-entry FIFO. It presents the buffered words to a local consumer over a valid/ready handshake. For every entry the consumer frees, it returns one credit pulse, which travels back to the sender through a 1-bit reverse `Channel`.

## Interface
- DWIDTH, 32, channel word width; bit DWIDTH-1 is the valid tag, bits DWIDTH-2:0 are payload.
- DEPTH, 128, FIFO entries.
  - Any integer ≥ 2; need not be a power of two.
  - Equals the sender's initial credit count.
  - Full throughput needs DEPTH ≥ forward DELAY + reverse DELAY + 2.
- CNTW, 8, width of the occupancy counter; requires DEPTH ≤ 2^CNTW − 1.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ch_in  input  DWIDTH  word from the forward channel output; an all-zero word (the channel's reset contents) is idle.
- out_data  output  DWIDTH-1  payload at the FIFO head.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head word.
- credit_out  output  1  one-cycle credit pulse into the reverse channel.
- count  output  CNTW  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky: a valid word arrived while full and was dropped.

## Operation
- Push: on each edge where ch_in[DWIDTH-1]=1, write ch_in[DWIDTH-2:0] at wr_ptr and advance wr_ptr. This happens only if the FIFO is not full, or if a pop occurs on the same edge.
- Pop: on each edge where out_valid=1 and out_ready=1, advance rd_ptr.
  - out_ready while out_valid=0 has no effect.
- Pointers: wr_ptr and rd_ptr wrap from DEPTH-1 to 0.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop when full: both take effect; count stays DEPTH; no drop.
- Simultaneous push and pop when count=1: the head word is consumed and the new word becomes the head next cycle; out_valid stays 1.
- Drop: a valid word with count=DEPTH and no pop on that edge is discarded.
  - overflow sets to 1 and holds until reset.
  - No pointer or count change.
  - No credit is generated for it.
- Credits: credit_out is registered and equals 1 in the cycle after each pop edge, otherwise 0.
  - Back-to-back pops give back-to-back credit pulses.
  - Credits are never coalesced or delayed further.
- Words with tag=0 are ignored regardless of payload.
- out_data is the head entry while out_valid=1 and is forced to 0 while out_valid=0.
- While out_valid=1 and out_ready=0, out_data holds stable.
- Reset: pointers, count, and overflow are cleared; FIFO contents are don't-care.
  - Outputs while reset is asserted: out_valid=0, out_data=0, credit_out=0, count=0, overflow=0.
  - Reset asserted mid-operation discards all buffered words and any pending credit pulse.
  - Restoring sender and receiver credit state consistently after a reset is the system's job: all endpoints and channels share rst_n.

## Timing
- Push-to-visible latency is 1 cycle. A valid word sampled at edge N gives out_valid=1 and count incremented after edge N, with no combinational bypass from ch_in.
- Pop-to-credit latency is 1 cycle. A pop at edge N gives credit_out=1 for the cycle between edges N and N+1.
- Every output is a register or a function of registers only. No combinational path from ch_in or out_ready to any output.
- Throughput: one push and one pop per cycle, sustained.
- Round trip:
  - A credit pulse reaches the sender DELAY_rev cycles after leaving credit_out.
  - The corresponding new word arrives DELAY_fwd cycles after the sender issues it.

## Test plan
- Reset and idle:
  - Stimulus: hold rst_n=0, then release with ch_in=0 for 10 cycles.
  - Required: all outputs stay 0 throughout.
- Single word:
  - Stimulus: ch_in={1'b1, 31'h1234_5678} for one cycle, out_ready=0.
  - Required, next cycle: out_valid=1, out_data=31'h1234_5678, count=1.
  - Required after raising out_ready: one cycle of pop, then credit_out=1 for exactly one cycle and count=0.
- Fill and overflow (DEPTH=4):
  - Stimulus: push payloads 1..5 on consecutive cycles with out_ready=0.
  - Required: count=4, overflow=1, no credits.
  - Required on draining: output order 1,2,3,4 and four credit pulses.
- Full with simultaneous push and pop (DEPTH=4):
  - Stimulus: from full, push 9 with out_ready=1 on the same edge.
  - Required: count stays 4, overflow stays 0, word 9 is delivered last.
- Wrap-around with DEPTH=5 (non-power-of-two):
  - Stimulus: stream 20 words with random out_ready, never exceeding credits.
  - Required: in-order delivery, no overflow, total credit pulses = 20.
- Loopback:
  - Stimulus: sender model with 8 credits, forward `Channel` DELAY=3, reverse `Channel` DWIDTH=1 DELAY=3, DEPTH=8, out_ready=1.
  - Required: steady state delivers 1 word/cycle with no drops.
  - Also: assert rst_n=0 mid-stream, then verify all outputs return to 0 and traffic restarts cleanly.

Source files
------------

// File: rtl/channel_rx.sv
// channel_rx: receive endpoint of a fixed-latency credit-based link.
//
// Words arriving from the forward channel with the valid tag set are buffered
// in a DEPTH-entry FIFO and offered to a local consumer over valid/ready.
// Each entry the consumer frees returns one registered credit pulse.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   ch_in       forward channel word: [DWIDTH-1] valid tag, [DWIDTH-2:0] payload
//   out_data    payload at the FIFO head (0 while empty)
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts the head word
//   credit_out  one-cycle pulse in the cycle after each pop
//   count       current occupancy, 0..DEPTH
//   overflow    sticky: a valid word arrived while full and was dropped
module channel_rx #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 128,
    parameter int CNTW   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] ch_in,
    output logic [DWIDTH-2:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              credit_out,
    output logic [CNTW-1:0]   count,
    output logic              overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DWIDTH-2:0] mem [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            credit_q, credit_d;
    logic            overflow_q, overflow_d;

    logic tag;
    logic full;
    logic push;
    logic pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        tag  = ch_in[DWIDTH-1];
        full = (count_q == CNTW'(DEPTH));
        pop  = (count_q != '0) && out_ready;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push = tag && (!full || pop);

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase

        credit_d   = pop;
        overflow_d = overflow_q | (tag & full & ~pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; stale contents are masked by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= ch_in[DWIDTH-2:0];
        end
    end

    always_comb begin
        out_valid  = (count_q != '0);
        out_data   = out_valid ? mem[rd_ptr_q] : '0;
        credit_out = credit_q;
        count      = count_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_channel_rx.sv
module tb_channel_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=4 instance: directed vector table
    logic [31:0] ch4 = '0;
    logic [30:0] od4;
    logic        ov4, rdy4 = 1'b0, cr4, of4;
    logic [2:0]  cnt4;
    // DEPTH=5 instance: wrap-around stream
    logic [31:0] ch5 = '0;
    logic [30:0] od5;
    logic        ov5, rdy5 = 1'b0, cr5, of5;
    logic [2:0]  cnt5;
    // DEPTH=8 instance: loopback through delayed channels
    logic [31:0] ch8;
    logic [30:0] od8;
    logic        ov8, rdy8 = 1'b0, cr8, of8;
    logic [3:0]  cnt8;

    channel_rx #(.DWIDTH(32), .DEPTH(4), .CNTW(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .ch_in(ch4), .out_data(od4), .out_valid(ov4),
        .out_ready(rdy4), .credit_out(cr4), .count(cnt4), .overflow(of4));
    channel_rx #(.DWIDTH(32), .DEPTH(5), .CNTW(3)) dut5 (
        .clk(clk), .rst_n(rst_n), .ch_in(ch5), .out_data(od5), .out_valid(ov5),
        .out_ready(rdy5), .credit_out(cr5), .count(cnt5), .overflow(of5));
    channel_rx #(.DWIDTH(32), .DEPTH(8), .CNTW(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .ch_in(ch8), .out_data(od8), .out_valid(ov8),
        .out_ready(rdy8), .credit_out(cr8), .count(cnt8), .overflow(of8));

    // Forward channel DELAY=3 (32 bit) and reverse channel DELAY=3 (1 bit)
    logic [31:0] snd8 = '0;
    logic [31:0] fwd_q [3];
    logic [2:0]  rev_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q[0] <= '0;
            fwd_q[1] <= '0;
            fwd_q[2] <= '0;
            rev_q    <= '0;
        end else begin
            fwd_q[0] <= snd8;
            fwd_q[1] <= fwd_q[0];
            fwd_q[2] <= fwd_q[1];
            rev_q    <= {rev_q[1:0], cr8};
        end
    end
    assign ch8 = fwd_q[2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        tag;
        logic [30:0] pay;
        logic        rdy;
        logic        ev;
        logic [30:0] ed;
        logic [2:0]  ec;
        logic        ecr;
        logic        eof;
    } vec_t;

    vec_t vt [20];

    int cred8 = 8;
    int seq8  = 0;
    int exp8  = 0;

    task automatic run_loop(input int cycles, input int win, output int win_pops);
        win_pops = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (rev_q[2]) cred8++;
            rdy8 = 1'b1;
            if (ov8) begin
                chk($sformatf("loop data %0d", exp8), {33'd0, od8}, {32'd0, 32'h200 + exp8});
                $display("loop pop  data=%h cnt=%0d", od8, cnt8);
                exp8++;
                if (c >= win) win_pops++;
            end
            if (cred8 > 0) begin
                snd8 = {1'b1, 31'(32'h200 + seq8)};
                seq8++;
                cred8--;
            end else begin
                snd8 = '0;
            end
        end
    endtask

    initial begin
        int sent, rcv, tot_cr, cred5, wp;

        // Directed table for DEPTH=4
        vt[0]  = '{1'b1, 31'h12345678, 1'b0, 1'b1, 31'h12345678, 3'd1, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 31'h0,        1'b0, 1'b1, 31'h12345678, 3'd1, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 31'h0,        1'b1, 1'b0, 31'h0,        3'd0, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 31'h0,        1'b0, 1'b0, 31'h0,        3'd0, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 31'd1,        1'b0, 1'b1, 31'd1,        3'd1, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 31'd2,        1'b0, 1'b1, 31'd1,        3'd2, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 31'd3,        1'b0, 1'b1, 31'd1,        3'd3, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 31'd4,        1'b0, 1'b1, 31'd1,        3'd4, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 31'd9,        1'b1, 1'b1, 31'd2,        3'd4, 1'b1, 1'b0}; // full push+pop
        vt[9]  = '{1'b1, 31'd5,        1'b0, 1'b1, 31'd2,        3'd4, 1'b0, 1'b1}; // dropped
        vt[10] = '{1'b0, 31'h0,        1'b1, 1'b1, 31'd3,        3'd3, 1'b1, 1'b1};
        vt[11] = '{1'b0, 31'h0,        1'b1, 1'b1, 31'd4,        3'd2, 1'b1, 1'b1};
        vt[12] = '{1'b0, 31'h0,        1'b1, 1'b1, 31'd9,        3'd1, 1'b1, 1'b1};
        vt[13] = '{1'b0, 31'h0,        1'b1, 1'b0, 31'h0,        3'd0, 1'b1, 1'b1};
        vt[14] = '{1'b0, 31'h0,        1'b0, 1'b0, 31'h0,        3'd0, 1'b0, 1'b1};
        vt[15] = '{1'b0, 31'h7FFFFFFF, 1'b1, 1'b0, 31'h0,        3'd0, 1'b0, 1'b1}; // tag 0
        vt[16] = '{1'b1, 31'h0AAAAAAA, 1'b0, 1'b1, 31'h0AAAAAAA, 3'd1, 1'b0, 1'b1};
        vt[17] = '{1'b1, 31'h05555555, 1'b1, 1'b1, 31'h05555555, 3'd1, 1'b1, 1'b1}; // count=1 both
        vt[18] = '{1'b0, 31'h0,        1'b1, 1'b0, 31'h0,        3'd0, 1'b1, 1'b1};
        vt[19] = '{1'b0, 31'h0,        1'b0, 1'b0, 31'h0,        3'd0, 1'b0, 1'b1};

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("reset dut4", {ov4, od4, cr4, cnt4, of4}, '0);
        chk("reset dut5", {ov5, od5, cr5, cnt5, of5}, '0);
        chk("reset dut8", {ov8, od8, cr8, cnt8, of8}, '0);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk($sformatf("idle %0d", c),
                {|{ov4, od4, cr4, cnt4, of4}, |{ov5, od5, cr5, cnt5, of5}, |{ov8, od8, cr8, cnt8, of8}}, '0);
        end

        // Table-driven vectors
        for (int i = 0; i < 20; i++) begin
            ch4  = {vt[i].tag, vt[i].pay};
            rdy4 = vt[i].rdy;
            @(posedge clk); #1;
            $display("vec %0d ch_in=%h rdy=%b -> valid=%b data=%h cnt=%0d credit=%b ovf=%b",
                     i, ch4, rdy4, ov4, od4, cnt4, cr4, of4);
            chk($sformatf("v%0d valid", i),    {63'd0, ov4}, {63'd0, vt[i].ev});
            chk($sformatf("v%0d data", i),     {33'd0, od4}, {33'd0, vt[i].ed});
            chk($sformatf("v%0d count", i),    {61'd0, cnt4}, {61'd0, vt[i].ec});
            chk($sformatf("v%0d credit", i),   {63'd0, cr4}, {63'd0, vt[i].ecr});
            chk($sformatf("v%0d overflow", i), {63'd0, of4}, {63'd0, vt[i].eof});
        end
        ch4  = '0;
        rdy4 = 1'b0;

        // DEPTH=5 wrap-around stream with random ready, sender bounded by credits
        sent = 0; rcv = 0; tot_cr = 0; cred5 = 5;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (cr5) begin
                cred5++;
                tot_cr++;
            end
            if (rcv == 20 && tot_cr == 20) break;
            rdy5 = 1'($urandom_range(0, 1));
            if (ov5 && rdy5) begin
                chk($sformatf("d5 order %0d", rcv), {33'd0, od5}, {32'd0, 32'h100 + rcv});
                $display("d5 pop  data=%h cnt=%0d", od5, cnt5);
                rcv++;
            end
            if (sent < 20 && cred5 > 0) begin
                ch5 = {1'b1, 31'(32'h100 + sent)};
                sent++;
                cred5--;
            end else begin
                ch5 = '0;
            end
        end
        ch5  = '0;
        rdy5 = 1'b0;
        chk("d5 received", 64'(rcv), 64'd20);
        chk("d5 credits", 64'(tot_cr), 64'd20);
        chk("d5 overflow", {63'd0, of5}, 64'd0);
        chk("d5 count", {61'd0, cnt5}, 64'd0);

        // Loopback, steady state one word per cycle
        run_loop(60, 20, wp);
        chk("loop throughput", 64'(wp), 64'd40);
        chk("loop overflow", {63'd0, of8}, 64'd0);

        // Reset mid-stream
        rst_n = 1'b0;
        #1;
        chk("midrst outputs", {ov8, od8, cr8, cnt8, of8}, '0);
        snd8 = '0; cred8 = 8; seq8 = 0; exp8 = 0;
        @(posedge clk); #1;
        chk("midrst held", {ov8, od8, cr8, cnt8, of8}, '0);
        chk("midrst chan", {rev_q, ch8}, '0);
        rst_n = 1'b1;
        run_loop(40, 20, wp);
        chk("restart throughput", 64'(wp), 64'd20);
        chk("restart overflow", {63'd0, of8}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
